// File: rtl/gshare_bp_if.sv
// gshare_bp_if: fetch lookup, resolve update and statistics bundle
// between the pipeline and the gshare predictor.
interface gshare_bp_if #(
  parameter int HIST_BITS = 6
);
  logic                 lookup_valid;
  logic [15:0]          lookup_pc;
  logic                 lookup_is_uncond;
  logic                 pred_taken;
  logic [15:0]          pred_target;
  logic [HIST_BITS-1:0] pred_hist;
  logic                 upd_valid;
  logic [15:0]          upd_pc;
  logic [HIST_BITS-1:0] upd_hist;
  logic                 upd_is_uncond;
  logic                 upd_taken;
  logic [15:0]          upd_target;
  logic                 upd_mispredict;
  logic                 stat_clear;
  logic [15:0]          stat_lookups;
  logic [15:0]          stat_mispredicts;

  modport master (
    output lookup_valid, lookup_pc, lookup_is_uncond,
    output upd_valid, upd_pc, upd_hist, upd_is_uncond,
    output upd_taken, upd_target, upd_mispredict,
    output stat_clear,
    input  pred_taken, pred_target, pred_hist,
    input  stat_lookups, stat_mispredicts
  );

  modport slave (
    input  lookup_valid, lookup_pc, lookup_is_uncond,
    input  upd_valid, upd_pc, upd_hist, upd_is_uncond,
    input  upd_taken, upd_target, upd_mispredict,
    input  stat_clear,
    output pred_taken, pred_target, pred_hist,
    output stat_lookups, stat_mispredicts
  );
endinterface

// File: rtl/gshare_bp.sv
// gshare_bp: gshare direction predictor with direct-mapped BTB,
// combinational lookup, resolve-time training, saturating stats.
module gshare_bp #(
  parameter int INDEX_BITS     = 6,
  parameter int HIST_BITS      = 6,
  parameter int BTB_INDEX_BITS = 4
) (
  input logic       clk,
  input logic       rst_n,
  gshare_bp_if.slave bp
);
  localparam int PHT_N = 1 << INDEX_BITS;
  localparam int BTB_N = 1 << BTB_INDEX_BITS;
  localparam int TAG_W = 15 - BTB_INDEX_BITS;

  typedef logic [INDEX_BITS-1:0]     pidx_t;
  typedef logic [BTB_INDEX_BITS-1:0] bidx_t;
  typedef logic [TAG_W-1:0]          tag_t;
  typedef logic [HIST_BITS-1:0]      hist_t;

  logic [1:0]  pht_q [PHT_N];
  hist_t       ghr_q, ghr_d;
  logic        btb_v_q   [BTB_N];
  tag_t        btb_tag_q [BTB_N];
  logic [15:0] btb_tgt_q [BTB_N];
  logic [15:0] lk_cnt_q, lk_cnt_d;
  logic [15:0] mp_cnt_q, mp_cnt_d;

  pidx_t      lk_idx, up_idx;
  bidx_t      lk_bi, up_bi;
  tag_t       lk_tag, up_tag;
  logic [1:0] lk_ctr, up_ctr, up_ctr_d;
  logic       lk_hit, lk_taken;
  logic       pht_wr, btb_wr;
  logic       unused_pc_lsb;

  // History occupies the low index bits; upper pc bits pass through.
  function automatic pidx_t pht_idx(logic [15:0] pc, hist_t h);
    pidx_t i;
    i = pc[INDEX_BITS:1];
    i[HIST_BITS-1:0] = i[HIST_BITS-1:0] ^ h;
    return i;
  endfunction

  assign unused_pc_lsb = bp.lookup_pc[0] ^ bp.upd_pc[0];

  always_comb begin
    lk_idx = pht_idx(bp.lookup_pc, ghr_q);
    lk_bi  = bp.lookup_pc[BTB_INDEX_BITS:1];
    lk_tag = bp.lookup_pc[15:BTB_INDEX_BITS+1];
    lk_ctr = pht_q[lk_idx];
    lk_hit = btb_v_q[lk_bi] && (btb_tag_q[lk_bi] == lk_tag);
    lk_taken = bp.lookup_valid & lk_hit
             & (bp.lookup_is_uncond | lk_ctr[1]);
  end

  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_taken ? btb_tgt_q[lk_bi]
                                   : bp.lookup_pc + 16'd2;
  assign bp.pred_hist   = ghr_q;

  always_comb begin
    up_idx   = pht_idx(bp.upd_pc, bp.upd_hist);
    up_bi    = bp.upd_pc[BTB_INDEX_BITS:1];
    up_tag   = bp.upd_pc[15:BTB_INDEX_BITS+1];
    up_ctr   = pht_q[up_idx];
    up_ctr_d = up_ctr;
    if (bp.upd_taken) begin
      if (up_ctr != 2'b11) up_ctr_d = up_ctr + 2'b01;
    end else begin
      if (up_ctr != 2'b00) up_ctr_d = up_ctr - 2'b01;
    end
    pht_wr = bp.upd_valid & ~bp.upd_is_uncond;
    btb_wr = bp.upd_valid & bp.upd_taken;
  end

  generate
    if (HIST_BITS == 1) begin : g_h1
      assign ghr_d = bp.upd_taken;
    end else begin : g_hn
      assign ghr_d = {ghr_q[HIST_BITS-2:0], bp.upd_taken};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
      ghr_q <= '0;
    end else if (pht_wr) begin
      pht_q[up_idx] <= up_ctr_d;
      ghr_q         <= ghr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else if (btb_wr) begin
      btb_v_q[up_bi]   <= 1'b1;
      btb_tag_q[up_bi] <= up_tag;
      btb_tgt_q[up_bi] <= bp.upd_target;
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    lk_cnt_d = lk_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (bp.lookup_valid && lk_cnt_q != 16'hFFFF)
      lk_cnt_d = lk_cnt_q + 16'd1;
    if (bp.upd_valid && bp.upd_mispredict && mp_cnt_q != 16'hFFFF)
      mp_cnt_d = mp_cnt_q + 16'd1;
    if (bp.stat_clear) begin
      lk_cnt_d = '0;
      mp_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      lk_cnt_q <= lk_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign bp.stat_lookups     = lk_cnt_q;
  assign bp.stat_mispredicts = mp_cnt_q;
endmodule

// File: tb/tb_gshare_bp.sv
// tb_gshare_bp: directed vectors for gshare_bp, one instance with
// 1-bit history and one with the default 6-bit history.
module tb_gshare_bp;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gshare_bp_if #(.HIST_BITS(1)) ia ();
  gshare_bp_if #(.HIST_BITS(6)) ib ();

  gshare_bp #(
    .INDEX_BITS(6), .HIST_BITS(1), .BTB_INDEX_BITS(4)
  ) u_a (.clk(clk), .rst_n(rst_n), .bp(ia));

  gshare_bp #(
    .INDEX_BITS(6), .HIST_BITS(6), .BTB_INDEX_BITS(4)
  ) u_b (.clk(clk), .rst_n(rst_n), .bp(ib));

  int vecs = 0;
  int errs = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic look_a(logic [15:0] pc, logic unc);
    ia.lookup_valid = 1'b1;
    ia.lookup_pc = pc;
    ia.lookup_is_uncond = unc;
    #1;
  endtask

  task automatic upd_a(logic [15:0] pc, logic h, logic unc,
                       logic tk, logic [15:0] tgt, logic mp);
    ia.upd_pc = pc;
    ia.upd_hist = h;
    ia.upd_is_uncond = unc;
    ia.upd_taken = tk;
    ia.upd_target = tgt;
    ia.upd_mispredict = mp;
    ia.upd_valid = 1'b1;
    @(negedge clk);
    ia.upd_valid = 1'b0;
    ia.upd_mispredict = 1'b0;
  endtask

  task automatic upd_b(logic [15:0] pc, logic [5:0] h,
                       logic tk, logic [15:0] tgt);
    ib.upd_pc = pc;
    ib.upd_hist = h;
    ib.upd_is_uncond = 1'b0;
    ib.upd_taken = tk;
    ib.upd_target = tgt;
    ib.upd_mispredict = 1'b0;
    ib.upd_valid = 1'b1;
    @(negedge clk);
    ib.upd_valid = 1'b0;
  endtask

  initial begin
    ia.lookup_valid = 0; ia.lookup_pc = 0; ia.lookup_is_uncond = 0;
    ia.upd_valid = 0; ia.upd_pc = 0; ia.upd_hist = 0;
    ia.upd_is_uncond = 0; ia.upd_taken = 0; ia.upd_target = 0;
    ia.upd_mispredict = 0; ia.stat_clear = 0;
    ib.lookup_valid = 0; ib.lookup_pc = 0; ib.lookup_is_uncond = 0;
    ib.upd_valid = 0; ib.upd_pc = 0; ib.upd_hist = 0;
    ib.upd_is_uncond = 0; ib.upd_taken = 0; ib.upd_target = 0;
    ib.upd_mispredict = 0; ib.stat_clear = 0;
    #1 rst_n = 1'b0;

    look_a(16'h3000, 1'b0);
    chk("rst_taken", 32'(ia.pred_taken), 0);
    chk("rst_tgt", 32'(ia.pred_target), 'h3002);
    chk("rst_hist", 32'(ia.pred_hist), 0);
    chk("rst_slk", 32'(ia.stat_lookups), 0);
    chk("rst_smp", 32'(ia.stat_mispredicts), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    look_a(16'h3000, 1'b1);
    chk("cold_jmp", 32'(ia.pred_taken), 0);

    upd_a(16'h3000, 1'b0, 1'b0, 1'b1, 16'h3040, 1'b0);
    look_a(16'h3000, 1'b0);
    chk("ghr_shift", 32'(ia.pred_hist), 1);
    chk("idx_xor_ghr", 32'(ia.pred_taken), 0);

    upd_a(16'h3006, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    look_a(16'h3000, 1'b0);
    chk("train_taken", 32'(ia.pred_taken), 1);
    chk("train_tgt", 32'(ia.pred_target), 'h3040);
    chk("train_hist", 32'(ia.pred_hist), 0);

    upd_a(16'h3000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    look_a(16'h3000, 1'b0);
    chk("ctr01_taken", 32'(ia.pred_taken), 0);
    chk("ctr01_tgt", 32'(ia.pred_target), 'h3002);
    upd_a(16'h3000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    look_a(16'h3000, 1'b0);
    chk("ctr00_taken", 32'(ia.pred_taken), 0);
    repeat (2) begin
      upd_a(16'h3000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      look_a(16'h3000, 1'b0);
      chk("ctr_floor", 32'(ia.pred_taken), 0);
    end
    repeat (4) upd_a(16'h3000, 1'b0, 1'b0, 1'b1, 16'h3040, 1'b0);
    upd_a(16'h3000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    look_a(16'h3000, 1'b0);
    chk("ctr_ceiling", 32'(ia.pred_taken), 1);

    upd_a(16'h3010, 1'b0, 1'b1, 1'b1, 16'h4000, 1'b0);
    look_a(16'h3010, 1'b1);
    chk("uncond_taken", 32'(ia.pred_taken), 1);
    chk("uncond_tgt", 32'(ia.pred_target), 'h4000);
    chk("uncond_ghr", 32'(ia.pred_hist), 0);
    look_a(16'h3010, 1'b0);
    chk("uncond_ctr", 32'(ia.pred_taken), 0);
    chk("uncond_ctr_tgt", 32'(ia.pred_target), 'h3012);

    upd_a(16'h3020, 1'b0, 1'b0, 1'b1, 16'h5000, 1'b0);
    look_a(16'h3000, 1'b1);
    chk("alias_miss", 32'(ia.pred_taken), 0);
    chk("alias_miss_tgt", 32'(ia.pred_target), 'h3002);
    look_a(16'h3020, 1'b1);
    chk("alias_hit_tgt", 32'(ia.pred_target), 'h5000);

    upd_a(16'h3008, 1'b0, 1'b1, 1'b1, 16'h6000, 1'b0);
    ia.upd_pc = 16'h3008; ia.upd_hist = 1'b1;
    ia.upd_is_uncond = 1'b0; ia.upd_taken = 1'b1;
    ia.upd_target = 16'h6000; ia.upd_valid = 1'b1;
    look_a(16'h3008, 1'b0);
    chk("rbw_old", 32'(ia.pred_taken), 0);
    chk("rbw_old_tgt", 32'(ia.pred_target), 'h300A);
    @(negedge clk);
    ia.upd_valid = 1'b0;
    look_a(16'h3008, 1'b0);
    chk("rbw_new", 32'(ia.pred_taken), 1);
    chk("rbw_new_tgt", 32'(ia.pred_target), 'h6000);

    look_a(16'hFFFE, 1'b0);
    chk("pc_wrap", 32'(ia.pred_target), 'h0000);

    ib.lookup_valid = 1'b1;
    ib.lookup_is_uncond = 1'b0;
    ib.lookup_pc = 16'h3000;
    upd_b(16'h3000, 6'h03, 1'b1, 16'h3080);
    #1 chk("b_hist1", 32'(ib.pred_hist), 'h01);
    upd_b(16'h3000, 6'h03, 1'b1, 16'h3080);
    #1;
    chk("b_xor_taken", 32'(ib.pred_taken), 1);
    chk("b_xor_tgt", 32'(ib.pred_target), 'h3080);
    chk("b_hist3", 32'(ib.pred_hist), 'h03);
    upd_b(16'h3100, 6'h00, 1'b0, 16'h0000);
    #1 chk("b_hist6", 32'(ib.pred_hist), 'h06);
    repeat (4) upd_b(16'h3102, 6'h00, 1'b1, 16'h3200);
    #1;
    chk("b_hist_trunc", 32'(ib.pred_hist), 'h2F);
    chk("b_newidx", 32'(ib.pred_taken), 0);

    ia.lookup_valid = 1'b1;
    ia.stat_clear = 1'b1;
    upd_a(16'h3030, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    ia.stat_clear = 1'b0;
    ia.lookup_valid = 1'b0;
    #1;
    chk("clr_mp", 32'(ia.stat_mispredicts), 0);
    chk("clr_lk", 32'(ia.stat_lookups), 0);
    repeat (3) upd_a(16'h3030, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    upd_a(16'h3030, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    ia.upd_mispredict = 1'b1;
    @(negedge clk);
    ia.upd_mispredict = 1'b0;
    #1;
    chk("mp_count", 32'(ia.stat_mispredicts), 3);
    chk("lk_idle", 32'(ia.stat_lookups), 0);
    ia.lookup_valid = 1'b1;
    repeat (5) @(negedge clk);
    ia.lookup_valid = 1'b0;
    #1 chk("lk_count", 32'(ia.stat_lookups), 5);
    ia.lookup_valid = 1'b1;
    repeat (65540) @(negedge clk);
    #1 chk("lk_sat", 32'(ia.stat_lookups), 'hFFFF);

    look_a(16'h3020, 1'b1);
    chk("pre_rst_taken", 32'(ia.pred_taken), 1);
    chk("pre_rst_hist", 32'(ia.pred_hist), 1);
    ia.upd_pc = 16'h3020; ia.upd_hist = 1'b0;
    ia.upd_is_uncond = 1'b1; ia.upd_taken = 1'b1;
    ia.upd_target = 16'h7000; ia.upd_mispredict = 1'b1;
    ia.upd_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_taken", 32'(ia.pred_taken), 0);
    chk("mid_rst_tgt", 32'(ia.pred_target), 'h3022);
    chk("mid_rst_hist", 32'(ia.pred_hist), 0);
    chk("mid_rst_slk", 32'(ia.stat_lookups), 0);
    chk("mid_rst_smp", 32'(ia.stat_mispredicts), 0);
    repeat (2) @(negedge clk);
    ia.upd_valid = 1'b0;
    ia.upd_mispredict = 1'b0;
    rst_n = 1'b1;
    look_a(16'h3020, 1'b1);
    chk("rst_discard", 32'(ia.pred_taken), 0);
    chk("rst_discard_smp", 32'(ia.stat_mispredicts), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
